// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one combinational ALU between two requesters. A request is
//   accepted in IDLE, its operation is registered and presented to the ALU
//   during EXEC, the ALU outputs are captured into a response register, and
//   the response is held in RESP until the owning requester takes it.
//
// Handshakes: every channel uses valid/ready. A transfer happens on a rising
//   edge of i_clk where both valid and ready are high. The requester keeps its
//   payload stable while valid && !ready. The arbiter never drops ready inside
//   a cycle while the valids are stable.
//
// Ports
//   i_clk, i_rst_n                 clock, async active-low reset
//   i_reqN_* / o_reqN_ready        request channel N (opsel, modifiers, operands)
//   o_alu_*                        operation register towards the ALU
//   i_alu_result/eq/slt            ALU outputs
//   o_rspN_valid / i_rspN_ready    response channel N
//   o_rspN_result/eq/slt           shared response register
//   o_dbg_state                    current FSM state (IDLE=0, EXEC=1, RESP=2)
module alu_arbiter #(
  parameter bit PRIORITY_RESET = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req0_valid,
  output logic        o_req0_ready,
  input  logic [2:0]  i_req0_opsel,
  input  logic        i_req0_sub,
  input  logic        i_req0_unsigned,
  input  logic        i_req0_arith,
  input  logic [31:0] i_req0_op1,
  input  logic [31:0] i_req0_op2,
  input  logic        i_req1_valid,
  output logic        o_req1_ready,
  input  logic [2:0]  i_req1_opsel,
  input  logic        i_req1_sub,
  input  logic        i_req1_unsigned,
  input  logic        i_req1_arith,
  input  logic [31:0] i_req1_op1,
  input  logic [31:0] i_req1_op2,
  output logic [2:0]  o_alu_opsel,
  output logic        o_alu_sub,
  output logic        o_alu_unsigned,
  output logic        o_alu_arith,
  output logic [31:0] o_alu_op1,
  output logic [31:0] o_alu_op2,
  input  logic [31:0] i_alu_result,
  input  logic        i_alu_eq,
  input  logic        i_alu_slt,
  output logic        o_rsp0_valid,
  input  logic        i_rsp0_ready,
  output logic [31:0] o_rsp0_result,
  output logic        o_rsp0_eq,
  output logic        o_rsp0_slt,
  output logic        o_rsp1_valid,
  input  logic        i_rsp1_ready,
  output logic [31:0] o_rsp1_result,
  output logic        o_rsp1_eq,
  output logic        o_rsp1_slt,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  logic        gnt;
  logic        prio;

  logic [2:0]  op_opsel;
  logic        op_sub;
  logic        op_unsigned;
  logic        op_arith;
  logic [31:0] op_op1;
  logic [31:0] op_op2;

  logic [31:0] rsp_result;
  logic        rsp_eq;
  logic        rsp_slt;

  logic        sel;
  logic        any_valid;
  logic        rsp_taken;

  // Grant choice: a lone valid wins, a tie goes to the round-robin pointer.
  // With no valid at all sel is 0, so requester 0 sees ready while idle.
  assign any_valid = i_req0_valid || i_req1_valid;
  assign sel       = (i_req0_valid && i_req1_valid) ? prio : i_req1_valid;

  // Ready is forced low during reset even though state already reads IDLE.
  assign o_req0_ready = i_rst_n && (state == IDLE) && !sel;
  assign o_req1_ready = i_rst_n && (state == IDLE) &&  sel;

  assign rsp_taken = gnt ? i_rsp1_ready : i_rsp0_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      gnt         <= 1'b0;
      prio        <= PRIORITY_RESET;
      op_opsel    <= 3'd0;
      op_sub      <= 1'b0;
      op_unsigned <= 1'b0;
      op_arith    <= 1'b0;
      op_op1      <= 32'd0;
      op_op2      <= 32'd0;
      rsp_result  <= 32'd0;
      rsp_eq      <= 1'b0;
      rsp_slt     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            gnt   <= sel;
            state <= EXEC;
            if (sel) begin
              op_opsel    <= i_req1_opsel;
              op_sub      <= i_req1_sub;
              op_unsigned <= i_req1_unsigned;
              op_arith    <= i_req1_arith;
              op_op1      <= i_req1_op1;
              op_op2      <= i_req1_op2;
            end else begin
              op_opsel    <= i_req0_opsel;
              op_sub      <= i_req0_sub;
              op_unsigned <= i_req0_unsigned;
              op_arith    <= i_req0_arith;
              op_op1      <= i_req0_op1;
              op_op2      <= i_req0_op2;
            end
          end
        end
        EXEC: begin
          rsp_result <= i_alu_result;
          rsp_eq     <= i_alu_eq;
          rsp_slt    <= i_alu_slt;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_taken) begin
            prio  <= ~gnt;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The ALU sees the operation register directly, so its inputs only move
  // when a new request is accepted.
  assign o_alu_opsel    = op_opsel;
  assign o_alu_sub      = op_sub;
  assign o_alu_unsigned = op_unsigned;
  assign o_alu_arith    = op_arith;
  assign o_alu_op1      = op_op1;
  assign o_alu_op2      = op_op2;

  assign o_rsp0_valid  = (state == RESP) && !gnt;
  assign o_rsp1_valid  = (state == RESP) &&  gnt;

  assign o_rsp0_result = rsp_result;
  assign o_rsp0_eq     = rsp_eq;
  assign o_rsp0_slt    = rsp_slt;
  assign o_rsp1_result = rsp_result;
  assign o_rsp1_eq     = rsp_eq;
  assign o_rsp1_slt    = rsp_slt;

  assign o_dbg_state = state;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter. A behavioural ALU answers the arbiter's o_alu_*
// outputs; expected responses come from fixed constants or from the same
// ALU function applied to the request payload as the requester issued it.
module tb_alu_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        req0_valid, req0_ready, req0_sub, req0_uns, req0_arith;
  logic [2:0]  req0_opsel;
  logic [31:0] req0_op1, req0_op2;
  logic        req1_valid, req1_ready, req1_sub, req1_uns, req1_arith;
  logic [2:0]  req1_opsel;
  logic [31:0] req1_op1, req1_op2;
  logic [2:0]  alu_opsel;
  logic        alu_sub, alu_uns, alu_arith, alu_eq, alu_slt;
  logic [31:0] alu_op1, alu_op2, alu_result;
  logic        rsp0_valid, rsp0_ready, rsp0_eq, rsp0_slt;
  logic [31:0] rsp0_result;
  logic        rsp1_valid, rsp1_ready, rsp1_eq, rsp1_slt;
  logic [31:0] rsp1_result;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  logic [33:0] exp_q0[$];
  logic [33:0] exp_q1[$];

  alu_arbiter #(.PRIORITY_RESET(1'b0)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0_valid(req0_valid), .o_req0_ready(req0_ready), .i_req0_opsel(req0_opsel),
    .i_req0_sub(req0_sub), .i_req0_unsigned(req0_uns), .i_req0_arith(req0_arith),
    .i_req0_op1(req0_op1), .i_req0_op2(req0_op2),
    .i_req1_valid(req1_valid), .o_req1_ready(req1_ready), .i_req1_opsel(req1_opsel),
    .i_req1_sub(req1_sub), .i_req1_unsigned(req1_uns), .i_req1_arith(req1_arith),
    .i_req1_op1(req1_op1), .i_req1_op2(req1_op2),
    .o_alu_opsel(alu_opsel), .o_alu_sub(alu_sub), .o_alu_unsigned(alu_uns),
    .o_alu_arith(alu_arith), .o_alu_op1(alu_op1), .o_alu_op2(alu_op2),
    .i_alu_result(alu_result), .i_alu_eq(alu_eq), .i_alu_slt(alu_slt),
    .o_rsp0_valid(rsp0_valid), .i_rsp0_ready(rsp0_ready), .o_rsp0_result(rsp0_result),
    .o_rsp0_eq(rsp0_eq), .o_rsp0_slt(rsp0_slt),
    .o_rsp1_valid(rsp1_valid), .i_rsp1_ready(rsp1_ready), .o_rsp1_result(rsp1_result),
    .o_rsp1_eq(rsp1_eq), .o_rsp1_slt(rsp1_slt),
    .o_dbg_state(dbg_state)
  );

  // ALU behaviour: returns {result, eq, slt}.
  function automatic logic [33:0] alu_fn(input logic [2:0] opsel, input logic sub,
                                         input logic uns, input logic arith,
                                         input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic lt;
    lt = uns ? (a < b) : ($signed(a) < $signed(b));
    case (opsel)
      3'd0: r = sub ? a - b : a + b;
      3'd1: r = a << b[4:0];
      3'd2: r = {31'd0, lt};
      3'd3: r = {31'd0, (a < b)};
      3'd4: r = a ^ b;
      3'd5: begin
        if (arith) r = $signed(a) >>> b[4:0];
        else       r = a >> b[4:0];
      end
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return {r, (a == b), lt};
  endfunction

  always_comb {alu_result, alu_eq, alu_slt} = alu_fn(alu_opsel, alu_sub, alu_uns, alu_arith, alu_op1, alu_op2);

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req0_valid = 0; req0_opsel = 0; req0_sub = 0; req0_uns = 0; req0_arith = 0; req0_op1 = 0; req0_op2 = 0;
    req1_valid = 0; req1_opsel = 0; req1_sub = 0; req1_uns = 0; req1_arith = 0; req1_op1 = 0; req1_op2 = 0;
    rsp0_ready = 0; rsp1_ready = 0;
  endtask

  task automatic apply_reset();
    rst_n = 0;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    tick();
  endtask

  task automatic set_req(input int n, input logic v, input logic [2:0] opsel, input logic sub,
                         input logic uns, input logic arith, input logic [31:0] a, input logic [31:0] b);
    if (n == 0) begin
      req0_valid = v; req0_opsel = opsel; req0_sub = sub; req0_uns = uns; req0_arith = arith;
      req0_op1 = a; req0_op2 = b;
    end else begin
      req1_valid = v; req1_opsel = opsel; req1_sub = sub; req1_uns = uns; req1_arith = arith;
      req1_op1 = a; req1_op2 = b;
    end
  endtask

  task automatic rand_req(input int n, input logic v);
    logic [31:0] a, b;
    a = $urandom;
    b = ($urandom_range(0, 3) == 0) ? a : $urandom;
    set_req(n, v, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), a, b);
  endtask

  // Presents a request, waits (bounded) for ready, and returns just after the
  // accepting edge with valid dropped.
  task automatic issue(input int n, input logic [2:0] opsel, input logic sub, input logic uns,
                       input logic arith, input logic [31:0] a, input logic [31:0] b);
    bit got;
    got = 0;
    set_req(n, 1'b1, opsel, sub, uns, arith, a, b);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if ((n == 0) ? req0_ready : req1_ready) got = 1;
      tick();
    end
    if (n == 0) req0_valid = 0; else req1_valid = 0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL issue_accept: req%0d ready not seen within 20 cycles", n);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    req0_valid = 1;
    req1_valid = 1;
    #2;
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_req0_ready: got %b want 0", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL reset_req1_ready: got %b want 0", req1_ready); end
    checks++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b want 00", {rsp0_valid, rsp1_valid}); end
    checks++; if ({alu_opsel, alu_sub, alu_uns, alu_arith, alu_op1, alu_op2} !== 70'd0) begin errors++; $display("FAIL reset_alu: op1 %h op2 %h opsel %h", alu_op1, alu_op2, alu_opsel); end
    checks++; if ({rsp0_result, rsp0_eq, rsp0_slt} !== 34'd0) begin errors++; $display("FAIL reset_rsp_payload: got %h want 0", {rsp0_result, rsp0_eq, rsp0_slt}); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    apply_reset();
  endtask

  task automatic test_add_latency();
    rsp0_ready = 1;
    set_req(0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 32'd5, 32'd7);
    @(negedge clk);
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL add_ready: got %b want 1", req0_ready); end
    tick();  // E0
    req0_valid = 0;
    @(negedge clk);
    checks++; if ({alu_op1, alu_op2} !== {32'd5, 32'd7}) begin errors++; $display("FAIL add_alu_ops: got %h/%h want 5/7", alu_op1, alu_op2); end
    checks++; if (rsp0_valid !== 1'b0) begin errors++; $display("FAIL add_rsp_early: got %b want 0", rsp0_valid); end
    tick();  // E1
    @(negedge clk);
    checks++; if (rsp0_valid !== 1'b1) begin errors++; $display("FAIL add_rsp_valid: got %b want 1", rsp0_valid); end
    checks++; if ({rsp0_result, rsp0_eq, rsp0_slt} !== {32'd12, 1'b0, 1'b1}) begin errors++; $display("FAIL add_rsp_payload: got %h %b %b want 12 0 1", rsp0_result, rsp0_eq, rsp0_slt); end
    checks++; if (rsp1_valid !== 1'b0) begin errors++; $display("FAIL add_rsp1_quiet: got %b want 0", rsp1_valid); end
    tick();  // E2, response taken
    @(negedge clk);
    checks++; if (rsp0_valid !== 1'b0 || dbg_state !== 2'd0) begin errors++; $display("FAIL add_back_idle: valid %b state %0d want 0 0", rsp0_valid, dbg_state); end
    checks++; if (alu_op1 !== 32'd5) begin errors++; $display("FAIL add_alu_hold: got %h want 5", alu_op1); end
    tick();
  endtask

  task automatic test_simultaneous();
    apply_reset();
    rsp0_ready = 1;
    rsp1_ready = 1;
    set_req(0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 32'd10, 32'd3);
    set_req(1, 1'b1, 3'd5, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'd4);
    @(negedge clk);
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL sim_first_grant: got %b want 10", {req0_ready, req1_ready}); end
    tick();  // E0
    req0_valid = 0;
    tick();  // E1
    @(negedge clk);
    checks++; if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd7) begin errors++; $display("FAIL sim_rsp0: valid %b result %h want 1 7", rsp0_valid, rsp0_result); end
    tick();  // E2
    @(negedge clk);
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL sim_second_grant: got %b want 1", req1_ready); end
    tick();  // E3
    req1_valid = 0;
    tick();
    @(negedge clk);
    checks++; if (rsp1_valid !== 1'b1 || rsp1_result !== 32'hF800_0000 || rsp0_valid !== 1'b0) begin
      errors++; $display("FAIL sim_rsp1: valid %b result %h rsp0 %b want 1 f8000000 0", rsp1_valid, rsp1_result, rsp0_valid);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int gnt_log[$];
    int cyc_log[$];
    int cyc;
    bit a0, a1;
    apply_reset();
    exp_q0.delete();
    exp_q1.delete();
    rsp0_ready = 1;
    rsp1_ready = 1;
    rand_req(0, 1'b1);
    rand_req(1, 1'b1);
    cyc = 0;
    while (cyc < 60 && !(gnt_log.size() == 6 && exp_q0.size() == 0 && exp_q1.size() == 0)) begin
      @(negedge clk);
      if (rsp0_valid) begin
        checks++;
        if (exp_q0.size() == 0 || {rsp0_result, rsp0_eq, rsp0_slt} !== exp_q0[0]) begin
          errors++; $display("FAIL b2b_rsp0: got %h", {rsp0_result, rsp0_eq, rsp0_slt});
        end
        if (exp_q0.size() != 0) void'(exp_q0.pop_front());
      end
      if (rsp1_valid) begin
        checks++;
        if (exp_q1.size() == 0 || {rsp1_result, rsp1_eq, rsp1_slt} !== exp_q1[0]) begin
          errors++; $display("FAIL b2b_rsp1: got %h", {rsp1_result, rsp1_eq, rsp1_slt});
        end
        if (exp_q1.size() != 0) void'(exp_q1.pop_front());
      end
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      if (a0) begin gnt_log.push_back(0); cyc_log.push_back(cyc); exp_q0.push_back(alu_fn(req0_opsel, req0_sub, req0_uns, req0_arith, req0_op1, req0_op2)); end
      if (a1) begin gnt_log.push_back(1); cyc_log.push_back(cyc); exp_q1.push_back(alu_fn(req1_opsel, req1_sub, req1_uns, req1_arith, req1_op1, req1_op2)); end
      tick();
      if (a0) rand_req(0, gnt_log.size() < 6);
      if (a1) rand_req(1, gnt_log.size() < 6);
      cyc++;
    end
    req0_valid = 0;
    req1_valid = 0;
    checks++;
    if (gnt_log.size() != 6 || exp_q0.size() != 0 || exp_q1.size() != 0) begin
      errors++; $display("FAIL b2b_count: %0d accepts, %0d/%0d responses pending, want 6 0 0", gnt_log.size(), exp_q0.size(), exp_q1.size());
    end
    for (int i = 0; i < gnt_log.size(); i++) begin
      checks++;
      if (gnt_log[i] != (i % 2)) begin errors++; $display("FAIL b2b_order: accept %0d went to req%0d want req%0d", i, gnt_log[i], i % 2); end
      if (i > 0) begin
        checks++;
        if (cyc_log[i] - cyc_log[i-1] != 3) begin errors++; $display("FAIL b2b_spacing: accept %0d gap %0d want 3", i, cyc_log[i] - cyc_log[i-1]); end
      end
    end
  endtask

  task automatic test_slt_backpressure();
    rsp1_ready = 0;
    issue(1, 3'd2, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1);  // now just after E0
    set_req(0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 32'd1, 32'd2);
    tick();  // E1
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rsp1_valid !== 1'b1 || {rsp1_result, rsp1_eq, rsp1_slt} !== {32'd1, 1'b0, 1'b1}) begin
        errors++; $display("FAIL bp_hold_%0d: valid %b payload %h want 1 {1,0,1}", i, rsp1_valid, {rsp1_result, rsp1_eq, rsp1_slt});
      end
      checks++;
      if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL bp_ready_%0d: got %b want 00", i, {req0_ready, req1_ready}); end
      tick();
    end
    rsp1_ready = 1;
    tick();  // response handshake
    req0_valid = 0;
    @(negedge clk);
    checks++; if (rsp1_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got %b want 0", rsp1_valid); end
    tick();
    issue(1, 3'd2, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1);
    tick();
    @(negedge clk);
    checks++;
    if (rsp1_valid !== 1'b1 || {rsp1_result, rsp1_eq, rsp1_slt} !== {32'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL sltu_rsp: valid %b payload %h want 1 {0,0,0}", rsp1_valid, {rsp1_result, rsp1_eq, rsp1_slt});
    end
    tick();
  endtask

  task automatic test_reset_mid_exec();
    rsp0_ready = 1;
    issue(0, 3'd0, 1'b0, 1'b0, 1'b0, 32'h1234, 32'd1);  // EXEC now
    req0_valid = 1;
    #2 rst_n = 0;
    #1;
    checks++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin errors++; $display("FAIL mid_rst_rsp: got %b want 00", {rsp0_valid, rsp1_valid}); end
    checks++; if (alu_op1 !== 32'd0) begin errors++; $display("FAIL mid_rst_alu_op1: got %h want 0", alu_op1); end
    checks++; if (req0_ready !== 1'b0 || dbg_state !== 2'd0) begin errors++; $display("FAIL mid_rst_ready: ready %b state %0d want 0 0", req0_ready, dbg_state); end
    req0_valid = 0;
    @(negedge clk);
    rst_n = 1;
    tick();
    issue(0, 3'd4, 1'b0, 1'b0, 1'b0, 32'hFF, 32'h0F);
    tick();
    @(negedge clk);
    checks++;
    if (rsp0_valid !== 1'b1 || rsp0_result !== 32'hF0) begin errors++; $display("FAIL xor_after_rst: valid %b result %h want 1 f0", rsp0_valid, rsp0_result); end
    tick();
  endtask

  // Random traffic against a transaction-level model: one operation in flight,
  // response visible from the second cycle after accept, ties broken toward
  // the requester that was not served last.
  task automatic test_random();
    bit m_busy, m_owner, m_prio;
    int m_age, win;
    bit a0, a1, done;
    logic [33:0] exp_v;
    apply_reset();
    exp_q0.delete();
    exp_q1.delete();
    m_busy = 0; m_owner = 0; m_prio = 0; m_age = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (m_busy) m_age++;
      checks++;
      if (rsp0_valid !== (m_busy && m_age >= 2 && !m_owner) || rsp1_valid !== (m_busy && m_age >= 2 && m_owner)) begin
        errors++; $display("FAIL rnd_rsp_valid c%0d: got %b%b", c, rsp1_valid, rsp0_valid);
      end
      if (m_busy) begin
        checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL rnd_busy_ready c%0d: got %b want 00", c, {req0_ready, req1_ready}); end
      end else if (req0_valid || req1_valid) begin
        win = (req0_valid && req1_valid) ? int'(m_prio) : int'(req1_valid);
        checks++;
        if (req0_ready !== (win == 0) || req1_ready !== (win == 1)) begin
          errors++; $display("FAIL rnd_grant c%0d: ready %b%b want winner req%0d", c, req1_ready, req0_ready, win);
        end
      end
      done = 0;
      if (m_busy && m_age >= 2) begin
        exp_v = m_owner ? exp_q1[0] : exp_q0[0];
        checks++;
        if ((m_owner ? {rsp1_result, rsp1_eq, rsp1_slt} : {rsp0_result, rsp0_eq, rsp0_slt}) !== exp_v) begin
          errors++; $display("FAIL rnd_payload c%0d req%0d: got %h want %h", c, m_owner,
                             m_owner ? {rsp1_result, rsp1_eq, rsp1_slt} : {rsp0_result, rsp0_eq, rsp0_slt}, exp_v);
        end
        done = m_owner ? rsp1_ready : rsp0_ready;
      end
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      if (done) begin
        if (m_owner) void'(exp_q1.pop_front()); else void'(exp_q0.pop_front());
        m_busy = 0; m_prio = ~m_owner;
      end
      if (a0 || a1) begin
        m_busy = 1; m_age = 0; m_owner = a1;
        if (a1) exp_q1.push_back(alu_fn(req1_opsel, req1_sub, req1_uns, req1_arith, req1_op1, req1_op2));
        else    exp_q0.push_back(alu_fn(req0_opsel, req0_sub, req0_uns, req0_arith, req0_op1, req0_op2));
      end
      tick();
      if (a0 || !req0_valid) rand_req(0, $urandom_range(0, 1) == 1);
      if (a1 || !req1_valid) rand_req(1, $urandom_range(0, 1) == 1);
      rsp0_ready = ($urandom_range(0, 9) < 7);
      rsp1_ready = ($urandom_range(0, 9) < 7);
    end
    clear_inputs();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    clear_inputs();
    test_reset();
    test_add_latency();
    test_simultaneous();
    test_back_to_back();
    test_slt_backpressure();
    test_reset_mid_exec();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
